// File: rtl/ifid_pkg.sv
// Shared types for the fetch/decode skid register: FSM state, beat payload and
// the instruction value decode sees while no beat is held.
package ifid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_beat_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam int unsigned BEAT_W            = $bits(ifid_beat_t);

  function automatic ifid_beat_t make_beat(input logic [31:0] pc, input logic [31:0] instr);
    ifid_beat_t b;
    b.pc    = pc;
    b.instr = instr;
    return b;
  endfunction

endpackage

// File: rtl/ifid_slot.sv
// One beat-wide holding register with load enable and async active-high reset.
module ifid_slot #(
  parameter int unsigned   W       = 64,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RST_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ifid_skid_reg.sv
// Fetch/decode two-entry skid register with a fully registered in_ready.
// Optional squash of held beats on redirect is enabled with `define IFID_FLUSH_EN.
module ifid_skid_reg
  import ifid_pkg::*;
#(
  parameter int unsigned  n         = 32,
  parameter logic [n-1:0] NOP_INSTR = n'(NOP_INSTR_DEFAULT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_pc,
  input  logic [n-1:0] in_instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_pc,
  output logic [n-1:0] out_instr,
  input  logic         flush
);

  localparam int unsigned  BW        = 2 * n;
  localparam logic [BW-1:0] IDLE_BEAT = {n'(0), NOP_INSTR};

  ifid_state_t   state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          main_ld, skid_ld;
  logic [BW-1:0] main_d, skid_d, main_q, skid_q;
  logic [BW-1:0] in_beat_c;
  logic          in_fire_c, out_fire_c, flush_c;

  assign in_beat_c  = {in_pc, in_instr};
  assign in_fire_c  = in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready;

`ifdef IFID_FLUSH_EN
  assign flush_c = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_c      = 1'b0;
`endif

  // Next state and slot loads; main always holds the head beat, or the idle beat when empty.
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    main_d  = main_q;
    skid_ld = 1'b0;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          state_d = ONE;
          main_ld = 1'b1;
          main_d  = in_beat_c;
        end
      end
      ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_ld = 1'b1;
          main_d  = in_beat_c;
        end else if (in_fire_c) begin
          state_d = TWO;
          skid_ld = 1'b1;
          skid_d  = in_beat_c;
        end else if (out_fire_c) begin
          state_d = EMPTY;
          main_ld = 1'b1;
          main_d  = IDLE_BEAT;
        end
      end
      TWO: begin
        if (out_fire_c) begin
          state_d = ONE;
          main_ld = 1'b1;
          main_d  = skid_q;
          skid_ld = 1'b1;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        main_ld = 1'b1;
        main_d  = IDLE_BEAT;
        skid_ld = 1'b1;
        skid_d  = '0;
      end
    endcase

    // Redirect overrides everything; a same-cycle out handshake is simply consumed.
    if (flush_c) begin
      state_d = EMPTY;
      main_ld = 1'b1;
      main_d  = IDLE_BEAT;
      skid_ld = 1'b1;
      skid_d  = '0;
    end

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  ifid_slot #(
    .W       (BW),
    .RST_VAL (IDLE_BEAT)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load_i (main_ld),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  ifid_slot #(
    .W       (BW),
    .RST_VAL ('0)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load_i (skid_ld),
    .d_i    (skid_d),
    .q_o    (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = main_q[BW-1 -: n];
  assign out_instr = main_q[n-1:0];

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Self-checking bench for ifid_skid_reg: directed scenarios plus a random
// valid/ready run against a FIFO scoreboard. Define IFID_FLUSH_EN to cover flush.
module tb_ifid_skid_reg;
  import ifid_pkg::*;

  localparam logic [31:0] NOP = NOP_INSTR_DEFAULT;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;

  int vectors     = 0;
  int miscompares = 0;

  ifid_beat_t sb[$];

  ifid_skid_reg #(.n(32), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    reset     = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_instr !== NOP) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b ready=%b pc=%h instr=%h, want 0 1 0 %h",
               out_valid, in_ready, out_pc, out_instr, NOP);
    end
  endtask

  task automatic test_single();
    ifid_beat_t exp;
    in_valid  = 1'b1;
    in_pc     = 32'h0040_0000;
    in_instr  = 32'h2008_0005;
    out_ready = 1'b1;
    sb.push_back(make_beat(in_pc, in_instr));
    tick();
    in_valid = 1'b0;
    exp = sb.pop_front();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== exp.pc || out_instr !== exp.instr || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_beat: got valid=%b ready=%b pc=%h instr=%h, want 1 1 %h %h",
               out_valid, in_ready, out_pc, out_instr, exp.pc, exp.instr);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== NOP) begin
      miscompares++;
      $display("FAIL single_drain: got valid=%b instr=%h, want 0 %h", out_valid, out_instr, NOP);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_0000;
    in_instr  = 32'hA000_0000;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_first: got valid=%b ready=%b pc=%h, want 1 1 0", out_valid, in_ready, out_pc);
    end
    in_pc    = 32'h0000_0004;
    in_instr = 32'hA000_0004;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL b2b_full: got ready=%b pc=%h instr=%h, want 0 0 a0000000", in_ready, out_pc, out_instr);
    end
    in_pc    = 32'h0000_0008;
    in_instr = 32'hA000_0008;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL b2b_hold: got ready=%b valid=%b pc=%h instr=%h, want 0 1 0 a0000000",
               in_ready, out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_pc !== 32'h4 || out_instr !== 32'hA000_0004 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: got pc=%h instr=%h ready=%b, want 4 a0000004 1", out_pc, out_instr, in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'hA000_0008) begin
      miscompares++;
      $display("FAIL b2b_third: got valid=%b pc=%h instr=%h, want 1 8 a0000008", out_valid, out_pc, out_instr);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_empty: got valid=%b instr=%h ready=%b, want 0 %h 1", out_valid, out_instr, in_ready, NOP);
    end
  endtask

  task automatic test_throughput();
    ifid_beat_t exp;
    int received = 0;
    int sent     = 0;
    out_ready = 1'b1;
    while (sent < 100 || sb.size() != 0) begin
      in_valid = (sent < 100);
      in_pc    = 32'h0000_1000 + 32'(sent) * 32'd4;
      in_instr = 32'hC000_0000 ^ 32'(sent);
      #1;
      if (sent > 0 && sent < 100) begin
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL tput_gap: beat %0d got valid=%b ready=%b, want 1 1", sent, out_valid, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL tput_extra: got pc=%h with nothing expected", out_pc);
        end else begin
          exp = sb.pop_front();
          if (out_pc !== exp.pc || out_instr !== exp.instr) begin
            miscompares++;
            $display("FAIL tput_data: got %h/%h want %h/%h", out_pc, out_instr, exp.pc, exp.instr);
          end
        end
        received++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(make_beat(in_pc, in_instr));
        sent++;
      end
      if (sent + received > 400) break;
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (received !== 100) begin
      miscompares++;
      $display("FAIL tput_count: got %0d beats want 100", received);
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_2000;
    in_instr  = 32'h1111_1111;
    tick();
    in_pc    = 32'h0000_2004;
    in_instr = 32'h2222_2222;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_setup: got ready=%b want 0", in_ready);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== NOP || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL areset_async: got valid=%b ready=%b pc=%h instr=%h, want 0 1 0 %h",
               out_valid, in_ready, out_pc, out_instr, NOP);
    end
    #1 reset = 1'b0;
    sb.delete();
    in_valid  = 1'b1;
    in_pc     = 32'h0000_3000;
    in_instr  = 32'h3333_3333;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instr !== 32'h3333_3333 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_after: got valid=%b ready=%b pc=%h instr=%h, want 1 1 3000 33333333",
               out_valid, in_ready, out_pc, out_instr);
    end
    tick();
  endtask

`ifdef IFID_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_pc    = 32'h0000_4000 + 32'(i) * 32'd4;
      in_instr = 32'h4444_0000 + 32'(i);
      tick();
    end
    in_pc    = 32'hDEAD_0000;
    in_instr = 32'hDEAD_BEEF;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== NOP) begin
      miscompares++;
      $display("FAIL flush_state: got valid=%b ready=%b instr=%h, want 0 1 %h", out_valid, in_ready, out_instr, NOP);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_pc === 32'hDEAD_0000) begin
      miscompares++;
      $display("FAIL flush_drop: got valid=%b pc=%h, want 0 and no flushed beat", out_valid, out_pc);
    end
  endtask
`endif

  task automatic test_random();
    ifid_beat_t  exp;
    logic        hold = 1'b0;
    logic        stalled = 1'b0;
    logic [31:0] prev_pc = '0, prev_instr = '0, next_pc = 32'h0001_0000;
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc    = next_pc;
        in_instr = $urandom();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      vectors++;
      if (in_ready !== (sb.size() < 2) || out_valid !== (sb.size() != 0)) begin
        miscompares++;
        $display("FAIL rnd_flags: cyc %0d got ready=%b valid=%b, held %0d", c, in_ready, out_valid, sb.size());
      end
      if (stalled) begin
        vectors++;
        if (out_pc !== prev_pc || out_instr !== prev_instr) begin
          miscompares++;
          $display("FAIL rnd_stable: cyc %0d got %h/%h want %h/%h", c, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      if (out_valid && sb.size() != 0) begin
        vectors++;
        if (out_pc !== sb[0].pc || out_instr !== sb[0].instr) begin
          miscompares++;
          $display("FAIL rnd_data: cyc %0d got %h/%h want %h/%h", c, out_pc, out_instr, sb[0].pc, sb[0].instr);
        end
      end else if (!out_valid) begin
        vectors++;
        if (out_instr !== NOP) begin
          miscompares++;
          $display("FAIL rnd_nop: cyc %0d got instr=%h want %h", c, out_instr, NOP);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) exp = sb.pop_front();
      if (in_valid && in_ready) begin
        sb.push_back(make_beat(in_pc, in_instr));
        next_pc = next_pc + 32'd4;
      end
      hold       = in_valid && !in_ready;
      stalled    = out_valid && !out_ready;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_throughput();
    test_async_reset();
`ifdef IFID_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
